// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the shift-register command sequencer:
// command opcodes and controller states, used by the RTL and its bench.
package shift_seq_ctrl_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_ROTL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Both SHL and ROTL move data toward the MSB and use the left strobe.
  function automatic logic isLeftOp(op_e op);
    return (op == OP_SHL) || (op == OP_ROTL);
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command/status bundle between the host FSM (master) and the sequencer (slave).
interface shift_seq_ctrl_if
  import shift_seq_ctrl_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = $clog2(N + 1)
);

  logic          cmd_valid;
  logic          cmd_ready;
  op_e           cmd_op;
  logic [CW-1:0] cmd_cnt;
  logic          cmd_fill;
  logic [N-1:0]  cmd_data;
  logic          abort;
  logic          busy;
  logic          done;
  logic          aborted;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_fill, cmd_data, abort,
    input  cmd_ready, busy, done, aborted
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_fill, cmd_data, abort,
    output cmd_ready, busy, done, aborted
  );

endinterface

// File: rtl/shift_cnt.sv
// Loadable down-counter that tracks the remaining shifts of a command and
// flags the cycle on which the final shift is being performed.
module shift_cnt #(
  parameter int CW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_loadVal,
  input  logic          i_dec,
  output logic          o_last
);

  logic [CW-1:0] r_count;

  // Load on command capture, count down once per shift cycle, never wrap below zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_last = (r_count == CW'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for an N-bit left/right/load shift register. Takes one
// command per handshake and drives the register strobes cycle by cycle,
// finishing with a single-cycle done pulse.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = $clog2(N + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  shift_seq_ctrl_if.slave        cmd_if,
  input  logic [N-1:0]           i_sr_out,
  output logic                   o_sr_left,
  output logic                   o_sr_right,
  output logic                   o_sr_load,
  output logic                   o_sr_sin,
  output logic [N-1:0]           o_sr_in
);

  state_e        r_state;
  state_e        w_nextState;
  op_e           r_op;
  logic          r_fill;
  logic [N-1:0]  r_data;
  logic          r_aborted;

  logic          w_accept;
  logic [CW-1:0] w_cntSat;
  logic          w_last;
  logic          w_inShift;

  logic          w_cmdReady;
  logic          w_busy;
  logic          w_done;
  logic          w_abortedOut;

  // Only the MSB is needed for rotation; the rest of the register is observed but unused.
  logic          w_unused_sr;
  assign w_unused_sr = ^i_sr_out[N-2:0];

  assign w_accept  = cmd_if.cmd_valid && (r_state == ST_IDLE);
  assign w_cntSat  = (cmd_if.cmd_cnt > CW'(N)) ? CW'(N) : cmd_if.cmd_cnt;
  assign w_inShift = (r_state == ST_SHIFT);

  shift_cnt #(.CW(CW)) u_cnt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_accept),
    .i_loadVal (w_cntSat),
    .i_dec     (w_inShift),
    .o_last    (w_last)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Command fields are latched at the handshake; the abort flag is sticky until the next command.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_op      <= OP_LOAD;
      r_fill    <= 1'b0;
      r_data    <= '0;
      r_aborted <= 1'b0;
    end else if (w_accept) begin
      r_op      <= cmd_if.cmd_op;
      r_fill    <= cmd_if.cmd_fill;
      r_data    <= cmd_if.cmd_data;
      r_aborted <= 1'b0;
    end else if (w_inShift && cmd_if.abort) begin
      r_aborted <= 1'b1;
    end
  end

  // Next-state selection and Moore decode of all strobes and status.
  always_comb begin
    w_nextState  = r_state;
    w_cmdReady   = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_abortedOut = 1'b0;
    o_sr_left    = 1'b0;
    o_sr_right   = 1'b0;
    o_sr_load    = 1'b0;
    o_sr_sin     = 1'b0;
    o_sr_in      = '0;
    case (r_state)
      ST_IDLE: begin
        w_cmdReady = 1'b1;
        w_busy     = 1'b0;
        if (w_accept) begin
          if (cmd_if.cmd_op == OP_LOAD) begin
            w_nextState = ST_LOAD;
          end else if (w_cntSat == '0) begin
            w_nextState = ST_DONE;
          end else begin
            w_nextState = ST_SHIFT;
          end
        end
      end
      ST_LOAD: begin
        o_sr_load   = 1'b1;
        o_sr_in     = r_data;
        w_nextState = ST_DONE;
      end
      ST_SHIFT: begin
        if (isLeftOp(r_op)) begin
          o_sr_left = 1'b1;
        end else begin
          o_sr_right = 1'b1;
        end
        o_sr_sin = (r_op == OP_ROTL) ? i_sr_out[N-1] : r_fill;
        if (cmd_if.abort || w_last) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_abortedOut = r_aborted;
        w_nextState  = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  assign cmd_if.cmd_ready = w_cmdReady;
  assign cmd_if.busy      = w_busy;
  assign cmd_if.done      = w_done;
  assign cmd_if.aborted   = w_abortedOut;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl paired with a 4-bit shift register model.
module tb_shift_seq_ctrl;
  import shift_seq_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int CW = 3;

  typedef struct {
    op_e          op;
    logic [CW-1:0] cnt;
    logic         fill;
    logic [N-1:0] data;
    int           abortAt;
    logic [N-1:0] expSr;
    logic         expAborted;
    int           expDone;
    int           expStrobes;
  } vec_t;

  typedef struct {
    logic [N-1:0] sr;
    logic         aborted;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] srReg = '0;
  logic         srLeft, srRight, srLoad, srSin;
  logic [N-1:0] srIn;

  int checks = 0;
  int errors = 0;
  sb_t sbQueue[$];
  vec_t vecs[12];

  shift_seq_ctrl_if #(.N(N), .CW(CW)) cmdIf ();

  shift_seq_ctrl #(.N(N), .CW(CW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .cmd_if     (cmdIf),
    .i_sr_out   (srReg),
    .o_sr_left  (srLeft),
    .o_sr_right (srRight),
    .o_sr_load  (srLoad),
    .o_sr_sin   (srSin),
    .o_sr_in    (srIn)
  );

  always #5 clk = ~clk;

  // Shift register datapath model driven by the controller strobes.
  always @(posedge clk) begin
    if (srLoad) srReg <= srIn;
    else if (srLeft) srReg <= {srReg[N-2:0], srSin};
    else if (srRight) srReg <= {srSin, srReg[N-1:1]};
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Per-cycle strobe legality and scoreboard pop on every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("strobe one-hot", 32'(srLeft) + 32'(srRight) + 32'(srLoad) <= 1, 1);
      if (!srLoad) checkOutput("sr_in idle zero", 32'(srIn), 0);
      if (!srLeft && !srRight) checkOutput("sr_sin idle zero", 32'(srSin), 0);
      if (cmdIf.done) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected done", 1, 0);
        end else begin
          sb_t e;
          e = sbQueue.pop_front();
          checkOutput("sb sr_out", 32'(srReg), 32'(e.sr));
          checkOutput("sb aborted", 32'(cmdIf.aborted), 32'(e.aborted));
        end
      end
    end
  end

  task automatic applyStimulus(input vec_t v, input int idx);
    int doneAt = 0;
    int nLeft = 0, nRight = 0, nLoad = 0;
    logic abSeen = 1'b0;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    checkOutput({tag, " ready"}, 32'(cmdIf.cmd_ready), 1);
    cmdIf.cmd_valid = 1'b1;
    cmdIf.cmd_op    = v.op;
    cmdIf.cmd_cnt   = v.cnt;
    cmdIf.cmd_fill  = v.fill;
    cmdIf.cmd_data  = v.data;
    sbQueue.push_back('{v.expSr, v.expAborted});
    @(posedge clk);
    #1;
    cmdIf.cmd_valid = 1'b0;
    cmdIf.cmd_cnt   = CW'($urandom);
    cmdIf.cmd_fill  = 1'($urandom);
    cmdIf.cmd_data  = N'($urandom);
    for (int j = 1; j <= 20 && doneAt == 0; j++) begin
      @(negedge clk);
      cmdIf.abort = (v.abortAt == j) || (v.abortAt < 0);
      if (srLeft) nLeft++;
      if (srRight) nRight++;
      if (srLoad) nLoad++;
      if (cmdIf.done) begin
        doneAt = j;
        abSeen = cmdIf.aborted;
      end
    end
    cmdIf.abort = 1'b0;
    if (doneAt == 0) begin
      checkOutput({tag, " done timeout"}, 0, 1);
    end else begin
      checkOutput({tag, " done cycle"}, 32'(doneAt), 32'(v.expDone));
      checkOutput({tag, " aborted"}, 32'(abSeen), 32'(v.expAborted));
      checkOutput({tag, " left count"}, 32'(nLeft), isLeftOp(v.op) ? 32'(v.expStrobes) : 0);
      checkOutput({tag, " right count"}, 32'(nRight), (v.op == OP_SHR) ? 32'(v.expStrobes) : 0);
      checkOutput({tag, " load count"}, 32'(nLoad), (v.op == OP_LOAD) ? 32'(v.expStrobes) : 0);
    end
  endtask

  initial begin
    vecs[0]  = '{OP_LOAD, 3'd0, 1'b0, 4'b1011,  0, 4'b1011, 1'b0, 2, 1};
    vecs[1]  = '{OP_SHL,  3'd2, 1'b0, 4'b0000,  0, 4'b1100, 1'b0, 3, 2};
    vecs[2]  = '{OP_LOAD, 3'd0, 1'b0, 4'b1001,  0, 4'b1001, 1'b0, 2, 1};
    vecs[3]  = '{OP_ROTL, 3'd1, 1'b0, 4'b0000,  0, 4'b0011, 1'b0, 2, 1};
    vecs[4]  = '{OP_ROTL, 3'd4, 1'b0, 4'b0000,  0, 4'b0011, 1'b0, 5, 4};
    vecs[5]  = '{OP_SHR,  3'd0, 1'b1, 4'b0000,  0, 4'b0011, 1'b0, 1, 0};
    vecs[6]  = '{OP_SHR,  3'd7, 1'b1, 4'b0000,  0, 4'b1111, 1'b0, 5, 4};
    vecs[7]  = '{OP_LOAD, 3'd0, 1'b0, 4'b0000,  0, 4'b0000, 1'b0, 2, 1};
    vecs[8]  = '{OP_SHL,  3'd4, 1'b1, 4'b0000,  2, 4'b0011, 1'b1, 3, 2};
    vecs[9]  = '{OP_SHL,  3'd2, 1'b1, 4'b0000,  2, 4'b1111, 1'b1, 3, 2};
    vecs[10] = '{OP_SHR,  3'd1, 1'b0, 4'b0000,  0, 4'b0111, 1'b0, 2, 1};
    vecs[11] = '{OP_LOAD, 3'd0, 1'b0, 4'b1010, -1, 4'b1010, 1'b0, 2, 1};

    cmdIf.cmd_valid = 1'b0;
    cmdIf.cmd_op    = OP_LOAD;
    cmdIf.cmd_cnt   = '0;
    cmdIf.cmd_fill  = 1'b0;
    cmdIf.cmd_data  = '0;
    cmdIf.abort     = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ready", 32'(cmdIf.cmd_ready), 1);
    checkOutput("reset busy", 32'(cmdIf.busy), 0);
    checkOutput("reset done", 32'(cmdIf.done), 0);
    checkOutput("reset strobes", 32'({srLeft, srRight, srLoad, srSin}), 0);
    checkOutput("reset sr_in", 32'(srIn), 0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

    // Abort while idle must do nothing.
    cmdIf.abort = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checkOutput("idle abort busy", 32'(cmdIf.busy), 0);
      checkOutput("idle abort ready", 32'(cmdIf.cmd_ready), 1);
      checkOutput("idle abort done", 32'(cmdIf.done), 0);
    end
    cmdIf.abort = 1'b0;

    // Reset asserted during the second shift cycle.
    @(negedge clk);
    cmdIf.cmd_valid = 1'b1;
    cmdIf.cmd_op    = OP_SHL;
    cmdIf.cmd_cnt   = 3'd4;
    cmdIf.cmd_fill  = 1'b0;
    @(posedge clk);
    #1;
    cmdIf.cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst seq shift1 left", 32'(srLeft), 1);
    @(negedge clk);
    checkOutput("rst seq shift2 busy", 32'(cmdIf.busy), 1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst seq strobes", 32'({srLeft, srRight, srLoad, srSin}), 0);
    checkOutput("rst seq busy", 32'(cmdIf.busy), 0);
    checkOutput("rst seq ready", 32'(cmdIf.cmd_ready), 1);
    checkOutput("rst seq done", 32'(cmdIf.done), 0);
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checkOutput("rst seq no done", 32'(cmdIf.done), 0);
    end

    // Back-to-back LOADs with cmd_valid held high: accepted every third cycle.
    @(negedge clk);
    cmdIf.cmd_valid = 1'b1;
    cmdIf.cmd_op    = OP_LOAD;
    cmdIf.cmd_data  = 4'b0101;
    for (int j = 0; j < 9; j++) begin
      if (j > 0) @(negedge clk);
      checkOutput($sformatf("b2b ready c%0d", j), 32'(cmdIf.cmd_ready), 32'(j % 3 == 0));
      checkOutput($sformatf("b2b load c%0d", j), 32'(srLoad), 32'(j % 3 == 1));
      checkOutput($sformatf("b2b done c%0d", j), 32'(cmdIf.done), 32'(j % 3 == 2));
      if (j % 3 == 0) sbQueue.push_back('{4'b0101, 1'b0});
    end
    cmdIf.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("b2b final idle", 32'(cmdIf.busy), 0);
    checkOutput("scoreboard drained", 32'(sbQueue.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
